// File: rtl/gpio_debounce_pkg.sv
// Shared definitions for the GPIO input conditioning blocks:
// debounce FSM state encodings and default parameter values.
package gpio_debounce_pkg;

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_WAIT_HI   = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_WAIT_LO   = 2'd3
  } gpio_state_t;

  // 10 us hold time at a 100 MHz system clock
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000;
  localparam int DEFAULT_CNT_W           = 16;
  localparam int DEFAULT_EVT_W           = 16;

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchroniser for an asynchronous GPIO pin.
// Shared by every GPIO input, so it carries no parameters.
module gpio_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  // Move the pin into the clk domain through two back-to-back flops
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/gpio_debounce.sv
// Debounced GPIO input: synchronises the pin, qualifies each level change
// over DEBOUNCE_CYCLES stable samples, emits rise/fall strobes and counts
// qualified rising edges in a saturating counter that software can clear.
module gpio_debounce
  import gpio_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W,
  parameter int EVT_W           = DEFAULT_EVT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_raw,
  input  logic             clr_count,
  output logic             out_level,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [EVT_W-1:0] evt_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [EVT_W-1:0] EVT_MAX  = '1;

  logic             s2;
  gpio_state_t      state;
  gpio_state_t      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_nxt;
  logic             rise_nxt;
  logic             fall_nxt;

  gpio_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (in_raw),
    .q   (s2)
  );

  // Register the FSM state, the qualification counter and all outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_STABLE_LO;
      cnt        <= '0;
      out_level  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      out_level  <= level_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
    end
  end

  // A bounce back to the old level abandons qualification; the last stable sample accepts
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = out_level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      ST_STABLE_LO: begin
        if (s2) begin
          state_nxt = ST_WAIT_HI;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT_HI: begin
        if (!s2) begin
          state_nxt = ST_STABLE_LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_STABLE_HI;
          level_nxt = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_STABLE_HI: begin
        if (!s2) begin
          state_nxt = ST_WAIT_LO;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT_LO: begin
        if (s2) begin
          state_nxt = ST_STABLE_HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_STABLE_LO;
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_STABLE_LO;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Count registered rise strobes, holding at full scale; a clear beats an increment
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_count <= '0;
    end else if (clr_count) begin
      evt_count <= '0;
    end else if (rise_pulse && (evt_count != EVT_MAX)) begin
      evt_count <= evt_count + EVT_W'(1);
    end
  end

endmodule

// File: tb/tb_gpio_debounce.sv
// Testbench for gpio_debounce: two instances (DEBOUNCE_CYCLES=4 with a 3-bit
// event counter, and DEBOUNCE_CYCLES=1) compared every cycle against a
// run-length reference model, plus table rows and corner-case sequences.
module tb_gpio_debounce;

  typedef struct {
    int s1;
    int s2;
    int lvl;
    int run;
    int rise;
    int fall;
    int evt;
  } model_t;

  typedef struct {
    int lvl;
    int rise;
    int fall;
    int evt;
  } exp_t;

  typedef struct {
    bit rst;
    bit din;
    bit clr;
    int cycles;
    int exp_lvl;
    int exp_evt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_a;
  logic        in_b;
  logic        clr;
  logic        lvl_a, rise_a, fall_a;
  logic [2:0]  evt_a;
  logic        lvl_b, rise_b, fall_b;
  logic [15:0] evt_b;

  model_t m_a = '{default: 0};
  model_t m_b = '{default: 0};
  exp_t   q_a[$];
  exp_t   q_b[$];
  vec_t   vecs[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;

  always #5 clk = ~clk;

  gpio_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(16), .EVT_W(3)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .in_raw     (in_a),
    .clr_count  (clr),
    .out_level  (lvl_a),
    .rise_pulse (rise_a),
    .fall_pulse (fall_a),
    .evt_count  (evt_a)
  );

  gpio_debounce #(.DEBOUNCE_CYCLES(1), .CNT_W(16), .EVT_W(16)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .in_raw     (in_b),
    .clr_count  (clr),
    .out_level  (lvl_b),
    .rise_pulse (rise_b),
    .fall_pulse (fall_b),
    .evt_count  (evt_b)
  );

  // Reference: a new level is taken after d+1 consecutive synchronised samples differing from it
  function automatic model_t model_step(model_t m, bit r, bit din, bit c, int d, int maxv);
    model_t n = m;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    n.s1   = din ? 1 : 0;
    n.s2   = m.s1;
    n.rise = 0;
    n.fall = 0;
    if (m.s2 != m.lvl) begin
      n.run = m.run + 1;
      if (n.run == d + 1) begin
        n.lvl  = m.s2;
        n.rise = (m.s2 == 1) ? 1 : 0;
        n.fall = (m.s2 == 0) ? 1 : 0;
        n.run  = 0;
      end
    end else begin
      n.run = 0;
    end
    if (c) n.evt = 0;
    else if (m.rise == 1 && m.evt < maxv) n.evt = m.evt + 1;
    return n;
  endfunction

  task automatic compare(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
    end
  endtask

  task automatic check_output();
    exp_t e;
    if (q_a.size() == 0 || q_b.size() == 0) begin
      compare("scoreboard_empty", 0, 1);
      return;
    end
    e = q_a.pop_front();
    compare("a.out_level", int'(lvl_a), e.lvl);
    compare("a.rise_pulse", int'(rise_a), e.rise);
    compare("a.fall_pulse", int'(fall_a), e.fall);
    compare("a.evt_count", int'(evt_a), e.evt);
    e = q_b.pop_front();
    compare("b.out_level", int'(lvl_b), e.lvl);
    compare("b.rise_pulse", int'(rise_b), e.rise);
    compare("b.fall_pulse", int'(fall_b), e.fall);
    compare("b.evt_count", int'(evt_b), e.evt);
  endtask

  task automatic apply_stimulus(input bit r, input bit a, input bit b, input bit c);
    rst  = r;
    in_a = a;
    in_b = b;
    clr  = c;
    m_a = model_step(m_a, r, a, c, 4, 7);
    m_b = model_step(m_b, r, b, c, 1, 65535);
    q_a.push_back('{lvl: m_a.lvl, rise: m_a.rise, fall: m_a.fall, evt: m_a.evt});
    q_b.push_back('{lvl: m_b.lvl, rise: m_b.rise, fall: m_b.fall, evt: m_b.evt});
    @(posedge clk);
    #1;
    cyc++;
    check_output();
  endtask

  task automatic wait_rise_a(input bit c_after);
    int k = 0;
    do begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
      k++;
    end while (!rise_a && k < 20);
    compare("a.rise_seen", int'(rise_a), 1);
    apply_stimulus(1'b0, 1'b1, 1'b0, c_after);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rise_at, fall_at, n_rise, n_fall, n_both;

    rst = 1'b1; in_a = 1'b0; in_b = 1'b0; clr = 1'b0;

    // reset with pin high, release, exact 7-edge qualification, evt one cycle later
    vecs.push_back('{rst: 1, din: 1, clr: 0, cycles: 5,  exp_lvl: 0, exp_evt: 0});
    vecs.push_back('{rst: 0, din: 1, clr: 0, cycles: 6,  exp_lvl: 0, exp_evt: 0});
    vecs.push_back('{rst: 0, din: 1, clr: 0, cycles: 1,  exp_lvl: 1, exp_evt: 0});
    vecs.push_back('{rst: 0, din: 1, clr: 0, cycles: 1,  exp_lvl: 1, exp_evt: 1});
    // clean falling edge leaves evt_count alone
    vecs.push_back('{rst: 0, din: 0, clr: 0, cycles: 10, exp_lvl: 0, exp_evt: 1});
    // glitches of 1, 2, 3 cycles and a 3/1/3 bounce
    vecs.push_back('{rst: 0, din: 1, clr: 0, cycles: 1,  exp_lvl: 0, exp_evt: 1});
    vecs.push_back('{rst: 0, din: 0, clr: 0, cycles: 6,  exp_lvl: 0, exp_evt: 1});
    vecs.push_back('{rst: 0, din: 1, clr: 0, cycles: 2,  exp_lvl: 0, exp_evt: 1});
    vecs.push_back('{rst: 0, din: 0, clr: 0, cycles: 6,  exp_lvl: 0, exp_evt: 1});
    vecs.push_back('{rst: 0, din: 1, clr: 0, cycles: 3,  exp_lvl: 0, exp_evt: 1});
    vecs.push_back('{rst: 0, din: 0, clr: 0, cycles: 6,  exp_lvl: 0, exp_evt: 1});
    vecs.push_back('{rst: 0, din: 1, clr: 0, cycles: 3,  exp_lvl: 0, exp_evt: 1});
    vecs.push_back('{rst: 0, din: 0, clr: 0, cycles: 1,  exp_lvl: 0, exp_evt: 1});
    vecs.push_back('{rst: 0, din: 1, clr: 0, cycles: 3,  exp_lvl: 0, exp_evt: 1});
    vecs.push_back('{rst: 0, din: 0, clr: 0, cycles: 8,  exp_lvl: 0, exp_evt: 1});

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].cycles; k++)
        apply_stimulus(vecs[i].rst, vecs[i].din, 1'b0, vecs[i].clr);
      compare($sformatf("vec%0d.out_level", i), int'(lvl_a), vecs[i].exp_lvl);
      compare($sformatf("vec%0d.evt_count", i), int'(evt_a), vecs[i].exp_evt);
    end

    // nine more qualified rises saturate the 3-bit counter at 7
    for (int r = 0; r < 9; r++) begin
      for (int k = 0; k < 8; k++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end
    compare("sat.evt_count", int'(evt_a), 7);

    // clear, one normal increment, then clear coinciding with an increment
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    compare("clr.evt_count", int'(evt_a), 0);
    wait_rise_a(1'b0);
    compare("inc.evt_count", int'(evt_a), 1);
    for (int k = 0; k < 8; k++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    wait_rise_a(1'b1);
    compare("clr_wins.evt_count", int'(evt_a), 0);

    // reset while WAIT_HI with cnt=2, then full requalification
    for (int k = 0; k < 8; k++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    compare("midrst.out_level", int'(lvl_a), 0);
    for (int k = 0; k < 6; k++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    compare("requal.early_level", int'(lvl_a), 0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    compare("requal.out_level", int'(lvl_a), 1);
    compare("requal.rise_pulse", int'(rise_a), 1);

    // DEBOUNCE_CYCLES=1: single-cycle pin pulse rejected, two-cycle pulse accepted
    for (int k = 0; k < 4; k++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    compare("d1.short_level", int'(lvl_b), 0);
    compare("d1.short_evt", int'(evt_b), 0);
    rise_at = -1; fall_at = -1; n_rise = 0; n_fall = 0; n_both = 0;
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(1'b0, 1'b1, (k < 2) ? 1'b1 : 1'b0, 1'b0);
      if (rise_b) begin n_rise++; rise_at = k; end
      if (fall_b) begin n_fall++; fall_at = k; end
      if (rise_b && fall_b) n_both++;
    end
    compare("d1.rise_cycle", rise_at, 3);
    compare("d1.fall_cycle", fall_at, 5);
    compare("d1.rise_count", n_rise, 1);
    compare("d1.fall_count", n_fall, 1);
    compare("d1.both_high", n_both, 0);
    compare("d1.evt_count", int'(evt_b), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
